// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined),
// LSB first, idle-high line, bit timing derived from clk.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
//
// Handshake: a byte is taken on any rising clk edge where tx_valid && tx_ready.
// tx_valid and tx_data are ignored while tx_ready is low. tx_ready is a registered
// output that is high exactly while the FSM is in IDLE. tx_busy is its complement.
module uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  // Whole clocks per line bit. The divide truncates. Configurations are expected
  // to give a value of 2 or more.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // The end of a bit period is reached when the baud counter hits its last count.
  logic bit_done;
  assign bit_done = (baud_cnt == LAST_CNT);

  assign tx_busy = ~tx_ready;

  // Frame sequencer. txd and tx_ready are registered, so the line never glitches.
  // The txd value for the next state is loaded on the same edge as the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            state    <= START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Bit 0 of the shift register is always the bit now on the line.
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_bit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx_ready <= 1'b1;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT = 10.
// A line monitor decodes every frame from txd and compares it with the scoreboard queue.
// Each frame is checked for data, stop bit, optional parity, and a constant level over every bit period.
module tb_uart_tx;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int C        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME  = NBITS * C;
  localparam int BUDGET = 5000;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge. Outputs are sampled on falling edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < BUDGET), 32'd1);
  endtask

  // Present a byte when the DUT is ready. The accept happens on the next rising edge.
  // When hold is 1, tx_valid is left high after the accept.
  task automatic send(input logic [7:0] d, input bit hold);
    wait_ready();
    tx_valid = 1'b1;
    tx_data  = d;
    exp_q.push_back(d);
    tick();
    if (!hold) tx_valid = 1'b0;
  endtask

  // Count consecutive falling-edge samples with tx_ready low.
  // The task returns on the first sample where tx_ready is high.
  task automatic measure_busy(output int len);
    len = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && len < BUDGET) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- line monitor ----------------
  logic [NBITS-1:0] mon_bits;
  logic             mon_stable;
  logic             mon_abort;
  logic [7:0]       mon_exp;

  // Decode frames from txd. A reset seen mid-frame discards the byte being sent.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_stable = 1'b1;
        mon_abort  = 1'b0;
        mon_bits   = '0;
        for (int b = 0; b < NBITS && !mon_abort; b++) begin
          for (int k = 0; k < C && !mon_abort; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst !== 1'b0) mon_abort = 1'b1;
            else if (k == 0) mon_bits[b] = txd;
            else if (txd !== mon_bits[b]) mon_stable = 1'b0;
          end
        end
        if (mon_abort) begin
          if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
        end else begin
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("data", 32'(mon_bits[8:1]), 32'(mon_exp));
`ifdef UART_TX_PARITY_EN
            check("parity", 32'(mon_bits[9]), 32'(^mon_exp));
`endif
            check("stop_bit", 32'(mon_bits[NBITS-1]), 32'd1);
            check("bit_timing", 32'(mon_stable), 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int len;
    int bad;
    logic [7:0] r;

    // Reset for two cycles, then the line must stay idle.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("idle_200", 32'(bad), 32'd0);

    // Single byte 0xA5 with a one-cycle valid pulse.
    send(8'hA5, 1'b0);
    measure_busy(len);
    check("frame_len_a5", 32'(len), 32'(FRAME));
    check("busy_after_a5", 32'(tx_busy), 32'd0);
    drain();

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    send(8'h00, 1'b1);
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    measure_busy(len);
    check("frame_len_b2b", 32'(len), 32'(FRAME));
    check("gap_txd", 32'(txd), 32'd1);
    @(negedge clk);
    check("gap_one_cycle_ready", 32'(tx_ready), 32'd0);
    check("gap_one_cycle_start", 32'(txd), 32'd0);
    tx_valid = 1'b0;
    measure_busy(len);
    check("frame_len_b2b_2", 32'(len), 32'(FRAME - 1));
    drain();

    // tx_data and tx_valid toggled during a frame must not disturb it.
    send(8'h81, 1'b0);
    repeat (30) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (40) @(negedge clk);
    tx_valid = 1'b0;
    drain();
    bad = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("no_extra_frame", 32'(bad), 32'd0);

    // A reset during data bit 3 of 0x55 aborts the frame at once.
    send(8'h55, 1'b0);
    repeat (44) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_ready", 32'(tx_ready), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    send(8'h0F, 1'b0);
    measure_busy(len);
    check("frame_len_0f", 32'(len), 32'(FRAME));
    drain();

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight, 0x03 has even weight.
    send(8'h07, 1'b0);
    measure_busy(len);
    check("frame_len_07", 32'(len), 32'd110);
    drain();
    send(8'h03, 1'b0);
    drain();
`endif

    // Random bytes, some sent back-to-back.
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      send(r, 1'b0);
    end
    drain();
    repeat (FRAME + 5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle_txd", 32'(txd), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
